// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - load/store sequencer between datapath and external data memory
// Optional WAIT timeout counter: define MEM_ACCESS_SEQ_TIMEOUT_EN.
module mem_access_seq #(
    parameter int          TIMEOUT    = 15,
    parameter logic [31:0] FAULT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{FAULT_DATA, 8'(TIMEOUT)};
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
            err       <= 1'b0;
            wait_cnt  <= 8'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (memread || memwrite) begin
                        // a simultaneous read+write request is treated as a store
                        state     <= WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
                        wait_cnt  <= 8'h0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
                    else if (wait_cnt == LAST_WAIT) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= FAULT_DATA;
                        end
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
`endif
                end
                // request lines still belong to the retiring instruction here
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (state == WAIT) || ((state == IDLE) && (memread || memwrite));

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed and randomized checks of mem_access_seq against a transaction model
module tb_mem_access_seq;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    // transaction-level reference state
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    mem_access_seq #(.TIMEOUT(TMO), .FAULT_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: idle request cycle, nwait WAIT cycles (ack in the last unless no_ack), then DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int nwait, input logic [31:0] rd_data,
                          input logic no_ack);
        logic we;
        int   waits;
        we = wr;
        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = d;
        #1;
        check("stall_req", {31'b0, stall}, 32'd1);
        check("req_idle", {31'b0, mem_req}, 32'd0);
        waits = no_ack ? TMO : nwait;
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            check("req_wait", {31'b0, mem_req}, 32'd1);
            check("we_wait", {31'b0, mem_we}, {31'b0, we});
            check("addr_wait", mem_addr, a);
            check("wdata_wait", mem_wdata, d);
            check("stall_wait", {31'b0, stall}, 32'd1);
            addr = $urandom; wdata = $urandom;
            mem_ack = (!no_ack && k == waits - 1);
            mem_rdata = mem_ack ? rd_data : $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (no_ack) begin
            if (!we) exp_rdata = 32'hDEADBEEF;
            exp_err = 1'b1;
        end else if (!we) begin
            exp_rdata = rd_data;
        end
        check("stall_done", {31'b0, stall}, 32'd0);
        check("req_done", {31'b0, mem_req}, 32'd0);
        check("rdata_done", rdata, exp_rdata);
        check("err_done", {31'b0, err}, {31'b0, exp_err});
        memread = 1'b0; memwrite = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // read with three WAIT cycles, then immediate-ack write
        access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h12345678, 1'b0);
        access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 1, 32'h0BAD0BAD, 1'b0);
        check("we_write", {31'b0, mem_we}, 32'd1);
        // read+write together behaves as a write
        access(1'b1, 1'b1, 32'h84, 32'h11112222, 2, 32'hFEEDFACE, 1'b0);

        // stray ack in IDLE
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_req", {31'b0, mem_req}, 32'd0);
        check("stray_rdata", rdata, exp_rdata);
        check("stray_stall", {31'b0, stall}, 32'd0);

        // randomized back-to-back accesses
        for (int i = 0; i < 30; i++) begin
            logic rd, wr;
            int   r;
            r  = $urandom_range(2, 0);
            rd = (r != 1);
            wr = (r != 0);
            access(rd, wr, $urandom, $urandom, $urandom_range(TMO - 1, 1), $urandom, 1'b0);
        end

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
        access(1'b1, 1'b0, 32'hC0, 32'h0, 0, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'hC4, 32'h77, 1, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'hC8, 32'h0, 2, 32'h13572468, 1'b0);
`else
        // without the timeout the access waits indefinitely
        @(negedge clk);
        memread = 1'b1; addr = 32'hC0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("hang_stall", {31'b0, stall}, 32'd1);
        end
        check("hang_err", {31'b0, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h2468ACE0;
        @(negedge clk);
        mem_ack = 1'b0; memread = 1'b0;
        exp_rdata = 32'h2468ACE0;
        check("hang_rdata", rdata, exp_rdata);
`endif

        // asynchronous reset while in WAIT
        @(negedge clk);
        memread = 1'b1; addr = 32'hE0;
        @(negedge clk);
        check("pre_rst_req", {31'b0, mem_req}, 32'd1);
        memread = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", {31'b0, mem_req}, 32'd0);
        check("arst_stall", {31'b0, stall}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_err", {31'b0, err}, 32'd0);
        exp_rdata = 32'h0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 32'hF0, 32'h0, 1, 32'h0F0F0F0F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles in WAIT without ack (1..255).
REQ-002 Parameter FAULT_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 memread  in  1  datapath load request, current instruction.
REQ-006 memwrite  in  1  datapath store request, current instruction.
REQ-007 addr  in  32  byte address (ALU result).
REQ-008 wdata  in  32  store data (register read port 2).
REQ-009 rdata  out  32  registered load data returned to writeback mux.
REQ-010 stall  out  1  freezes PC and register-file write while access is in flight.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 mem_req  out  1  registered request to external data memory.
REQ-013 mem_we  out  1  registered write strobe, qualifies mem_req.
REQ-014 mem_addr  out  32  registered address, stable while mem_req high.
REQ-015 mem_wdata  out  32  registered write data, stable while mem_req high.
REQ-016 mem_rdata  in  32  memory read data, sampled only with mem_ack.
REQ-017 mem_ack  in  1  one-cycle completion strobe from memory.

Function
REQ-018 FSM states are IDLE, WAIT and DONE.
REQ-019 IDLE: when memread or memwrite is high, go to WAIT and latch addr, wdata and mem_we; also set mem_req high on that edge.
REQ-020 stall is combinational: high in IDLE when memread or memwrite is high, high throughout WAIT, low in DONE.
REQ-021 If memread and memwrite are both high, the access is a write (mem_we=1) and rdata is not updated.
REQ-022 WAIT: mem_req, mem_we, mem_addr and mem_wdata are held constant until mem_ack is sampled high.
REQ-023 On mem_ack in WAIT, capture mem_rdata into rdata on reads only, clear mem_req on the same edge, and go to DONE.
REQ-024 A mem_ack arriving in the same cycle mem_req first rises is valid, giving minimum latency: request at cycle 0, ack at cycle 1, DONE at cycle 2.
REQ-025 DONE lasts exactly one cycle, then goes to IDLE; memread/memwrite are ignored in DONE, because they still belong to the retiring instruction.
REQ-026 rdata holds its value until the next read completes.
REQ-027 mem_ack outside WAIT is ignored, with no state or output change.
REQ-028 A back-to-back access re-enters WAIT from the IDLE cycle after DONE; mem_req is low for at least one cycle between accesses.

Reset
REQ-029 Asserting rst (low) asynchronously forces: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, err 0, timeout counter 0.
REQ-030 Reset mid-access abandons the transaction; the first edge after deassertion evaluates IDLE normally.

Configuration
REQ-031 Macro MEM_ACCESS_SEQ_TIMEOUT_EN compiles in an 8-bit WAIT-cycle counter.
REQ-032 With the macro defined:
- The counter clears on entry to WAIT.
- If it reaches TIMEOUT without mem_ack, clear mem_req, load rdata with FAULT_DATA (reads only), set err, and go to DONE.
- err stays set until reset.
- mem_ack and timeout in the same cycle: the ack wins.
REQ-033 With the macro undefined, WAIT persists indefinitely, err is tied 0, and no counter exists.

Verification
REQ-034 Read, addr=0x40, mem_rdata=0x12345678 with ack 3 cycles after mem_req -> stall high 4 cycles, rdata=0x12345678 in DONE, mem_req low in DONE.
REQ-035 Write, addr=0x80, wdata=0xA5A5A5A5, immediate ack -> mem_we=1, mem_addr/mem_wdata stable while mem_req high, stall high 2 cycles, rdata unchanged.
REQ-036 memread=memwrite=1 -> write issued, rdata unchanged; stray mem_ack in IDLE -> no change.
REQ-037 rst low while in WAIT -> mem_req=0 and state IDLE immediately, without waiting for a clock edge; outputs at reset values.
REQ-038 TIMEOUT_EN defined, TIMEOUT=4, no ack -> after 4 WAIT cycles rdata=0xDEADBEEF, err=1 and held through the following accesses; undefined -> stall remains high.
